ram_fifo_controller: RTL

Pointer and flag controller that turns an external `dual_port_ram` instance into a first-word-fall-through FIFO. It sits directly upstream of the RAM: it owns the write and read ports of the RAM, and it presents a push/pop interface with full/empty, level, threshold and sticky error flags to the producer and consumer. The RAM stores data only; all ordering, occupancy and protection logic lives here.

---
 rtl/ram_fifo_controller_pkg.sv | 15 +
 rtl/ram_fifo_controller_pointer.sv | 34 +++
 rtl/ram_fifo_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/ram_fifo_controller_pkg.sv
// rtl/ram_fifo_controller_pkg.sv - shared helpers for the RAM-backed FIFO controller
package ram_fifo_controller_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_fifo_controller_pointer.sv
// rtl/ram_fifo_controller_pointer.sv - wrap-bit FIFO pointer with full or empty compare
module fifo_pointer #(
    parameter int ADDRESS_WIDTH = 4,
    parameter bit DETECT_FULL   = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     advance,
    input  logic [ADDRESS_WIDTH:0]   other_pointer,
    output logic [ADDRESS_WIDTH:0]   pointer,
    output logic                     flag
);

    logic [ADDRESS_WIDTH:0] r_pointer;
    logic                   w_same;
    logic                   w_lapped;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pointer <= '0;
        end else if (advance) begin
            r_pointer <= r_pointer + 1'b1;
        end
    end

    // Same low bits with differing wrap bits means one pointer is a full lap ahead.
    assign w_same   = (r_pointer == other_pointer);
    assign w_lapped = (r_pointer[ADDRESS_WIDTH-1:0] == other_pointer[ADDRESS_WIDTH-1:0])
                   && (r_pointer[ADDRESS_WIDTH] != other_pointer[ADDRESS_WIDTH]);

    assign pointer = r_pointer;
    assign flag    = DETECT_FULL ? w_lapped : w_same;

endmodule

// File: rtl/ram_fifo_controller.sv
// rtl/ram_fifo_controller.sv - FWFT FIFO pointer/flag controller driving an external dual-port RAM
module ram_fifo_controller
    import ram_fifo_controller_pkg::*;
#(
    parameter int WIDTH                  = 8,
    parameter int DEPTH                  = 16,
    parameter int ADDRESS_WIDTH          = clog2(DEPTH),
    parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [WIDTH-1:0]         write_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     read_enable,
    output logic [WIDTH-1:0]         read_data,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_errors,
    output logic                     memory_write_enable,
    output logic [ADDRESS_WIDTH-1:0] memory_write_address,
    output logic [WIDTH-1:0]         memory_write_data,
    output logic                     memory_read_enable,
    output logic [ADDRESS_WIDTH-1:0] memory_read_address,
    input  logic [WIDTH-1:0]         memory_read_data
);

    localparam logic [ADDRESS_WIDTH:0] ALMOST_FULL_LEVEL  = ALMOST_FULL_THRESHOLD[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] ALMOST_EMPTY_LEVEL = ALMOST_EMPTY_THRESHOLD[ADDRESS_WIDTH:0];

    logic [ADDRESS_WIDTH:0] w_write_pointer;
    logic [ADDRESS_WIDTH:0] w_read_pointer;
    logic                   w_push;
    logic                   w_pop;
    logic                   r_overflow;
    logic                   r_underflow;

    assign w_push = write_enable & ~full;
    assign w_pop  = read_enable & ~empty;

    fifo_pointer #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DETECT_FULL   (1'b1)
    ) u_write_pointer (
        .clock         (clock),
        .reset         (reset),
        .advance       (w_push),
        .other_pointer (w_read_pointer),
        .pointer       (w_write_pointer),
        .flag          (full)
    );

    fifo_pointer #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DETECT_FULL   (1'b0)
    ) u_read_pointer (
        .clock         (clock),
        .reset         (reset),
        .advance       (w_pop),
        .other_pointer (w_write_pointer),
        .pointer       (w_read_pointer),
        .flag          (empty)
    );

    // Modular subtraction of the extended pointers gives 0..DEPTH directly.
    assign level        = w_write_pointer - w_read_pointer;
    assign almost_full  = (level >= ALMOST_FULL_LEVEL);
    assign almost_empty = (level <= ALMOST_EMPTY_LEVEL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear_errors) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_enable && full) begin
                r_overflow <= 1'b1;
            end
            if (read_enable && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    assign memory_write_enable  = w_push;
    assign memory_write_address = w_write_pointer[ADDRESS_WIDTH-1:0];
    assign memory_write_data    = write_data;

    assign memory_read_enable  = ~empty;
    assign memory_read_address = w_read_pointer[ADDRESS_WIDTH-1:0];
    assign read_data           = empty ? '0 : memory_read_data;

endmodule
